mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: the fetch port, the Mem-stage port and the SRAM port of the shared memory arbiter.
// The slave modport is the arbiter; the master modport is the pipeline/SRAM side around it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BE_W   = 4
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;
    logic              stall_req;
    logic              sram_req;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [BE_W-1:0]   sram_be;
    logic              sram_ack;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be, sram_ack, sram_rdata,
        output if_ack, if_rdata, mem_ack, mem_rdata, err, stall_req,
               sram_req, sram_we, sram_addr, sram_wdata, sram_be
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be, sram_ack, sram_rdata,
        input  if_ack, if_rdata, mem_ack, mem_rdata, err, stall_req,
               sram_req, sram_we, sram_addr, sram_wdata, sram_be
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported SRAM between fetch and the Mem stage, one transaction at a time with a watchdog.
// Define ARB_ROUND_ROBIN_EN to alternate grants on conflicts; by default MEM always wins.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int BE_W    = 4,
    parameter int TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
    typedef struct packed {
        logic              sram_req;
        logic              sram_we;
        logic [ADDR_W-1:0] sram_addr;
        logic [DATA_W-1:0] sram_wdata;
        logic [BE_W-1:0]   sram_be;
        logic              if_ack;
        logic              mem_ack;
        logic              err;
        logic [DATA_W-1:0] if_rdata;
        logic [DATA_W-1:0] mem_rdata;
    } out_t;

    state_t            state, state_n;
    logic [7:0]        cnt, cnt_n;
    out_t              q, q_n;
    logic              pend_if, pend_mem, grant_mem, done;
    logic [DATA_W-1:0] rdata;

    // A requester whose ack is on the bus has not dropped its level request yet, so it is not pending.
    assign pend_if       = bus.if_req & ~q.if_ack;
    assign pend_mem      = bus.mem_req & ~q.mem_ack;
    assign bus.stall_req = pend_if | pend_mem;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_mem;
    assign grant_mem = pend_mem & (~pend_if | ~last_mem);
    always_ff @(posedge clk or posedge rst)
        if (rst)
            last_mem <= 1'b0;
        else if (state == IDLE && (pend_if | pend_mem))
            last_mem <= grant_mem;
`else
    assign grant_mem = pend_mem;
`endif

    assign done  = bus.sram_ack || cnt == 8'(TIMEOUT - 1);
    assign rdata = bus.sram_ack ? bus.sram_rdata : '0;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        q_n        = q;
        q_n.if_ack  = 1'b0;
        q_n.mem_ack = 1'b0;
        q_n.err     = 1'b0;
        if (state == IDLE) begin
            if (pend_if | pend_mem) begin
                state_n        = grant_mem ? BUSY_MEM : BUSY_IF;
                cnt_n          = '0;
                q_n.sram_req   = 1'b1;
                q_n.sram_we    = grant_mem & bus.mem_we;
                q_n.sram_addr  = grant_mem ? bus.mem_addr : bus.if_addr;
                q_n.sram_wdata = (grant_mem & bus.mem_we) ? bus.mem_wdata : '0;
                q_n.sram_be    = (grant_mem & bus.mem_we) ? bus.mem_be : '1;
            end
        end else if (done) begin
            state_n       = IDLE;
            q_n.sram_req  = 1'b0;
            q_n.err       = ~bus.sram_ack;
            q_n.if_ack    = state == BUSY_IF;
            q_n.mem_ack   = state == BUSY_MEM;
            q_n.if_rdata  = (state == BUSY_IF) ? rdata : q.if_rdata;
            q_n.mem_rdata = (state == BUSY_MEM && !q.sram_we) ? rdata : q.mem_rdata;
        end else begin
            cnt_n = cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            q     <= q_n;
        end

    assign bus.sram_req   = q.sram_req;
    assign bus.sram_we    = q.sram_we;
    assign bus.sram_addr  = q.sram_addr;
    assign bus.sram_wdata = q.sram_wdata;
    assign bus.sram_be    = q.sram_be;
    assign bus.if_ack     = q.if_ack;
    assign bus.mem_ack    = q.mem_ack;
    assign bus.err        = q.err;
    assign bus.if_rdata   = q.if_rdata;
    assign bus.mem_rdata  = q.mem_rdata;
endmodule
